// File: rtl/aes_selftest_sequencer.sv
// ============================================================================
// Module   : aes_selftest_sequencer
// Brief    : FIPS-197 known-answer encrypt/decrypt self-test sequencer for an
//            external AES core (128/192/256-bit keys).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_selftest_sequencer #(
    parameter int DATA_W    = 128,
    parameter int TIMEOUT   = 64,
    parameter int DISP_BYTE = 15,
    parameter int RND_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              auto_all,
    input  logic [1:0]        mode_sel,
    output logic              core_start,
    output logic [1:0]        core_mode,
    output logic              core_decrypt,
    output logic [DATA_W-1:0] core_din,
    input  logic              core_round_valid,
    input  logic [DATA_W-1:0] core_dout,
    input  logic              core_done,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        pass_mask,
    output logic [2:0]        fail_mask,
    output logic [RND_W-1:0]  round_num,
    output logic              phase,
    output logic [7:0]        disp_byte
);

    localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DISP_LSB = DATA_W - 8 * (DISP_BYTE + 1);

    localparam logic [DATA_W-1:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DATA_W-1:0] C_CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DATA_W-1:0] C_CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [DATA_W-1:0] C_CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_NEXT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_core_start;
    logic                w_done;

    logic [1:0]          r_mode;
    logic                r_auto;
    logic                r_phase;
    logic                r_busy;
    logic                r_pass;
    logic [2:0]          r_pass_mask;
    logic [2:0]          r_fail_mask;
    logic [RND_W-1:0]    r_round;
    logic [TMO_W-1:0]    r_tmo;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_din;
    logic [7:0]          r_disp;

    logic                w_illegal;
    logic [DATA_W-1:0]   w_expect;
    logic [RND_W-1:0]    w_rounds_exp;
    logic                w_check_ok;
    logic                w_tmo_hit;
    logic [2:0]          w_mode_bit;
    logic [2:0]          w_tested;
    logic                w_more;

    assign w_illegal    = start && !auto_all && (mode_sel == 2'd3);
    assign w_rounds_exp = RND_W'(11) + RND_W'({r_mode, 1'b0});
    assign w_check_ok   = (r_result == w_expect) && (r_round == w_rounds_exp);
    assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_mode_bit   = 3'b001 << r_mode;
    assign w_tested     = r_auto ? 3'b111 : w_mode_bit;
    assign w_more       = r_auto && (r_mode < 2'd2);

    always_comb begin
        w_expect = C_PT;
        if (!r_phase) begin
            case (r_mode)
                2'd0:    w_expect = C_CT0;
                2'd1:    w_expect = C_CT1;
                default: w_expect = C_CT2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_core_start = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = w_illegal ? S_FINISH : S_LAUNCH;
            S_LAUNCH: begin
                w_core_start = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (core_done)      w_next = S_CHECK;
                else if (w_tmo_hit) w_next = S_NEXT;
            end
            // Decrypt is only attempted after a good encrypt.
            S_CHECK:  w_next = (w_check_ok && !r_phase) ? S_LAUNCH : S_NEXT;
            S_NEXT:   w_next = w_more ? S_LAUNCH : S_FINISH;
            S_FINISH: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= 2'd0;
            r_auto      <= 1'b0;
            r_phase     <= 1'b0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_pass_mask <= 3'b000;
            r_fail_mask <= 3'b000;
            r_round     <= '0;
            r_tmo       <= '0;
            r_result    <= '0;
            r_din       <= '0;
            r_disp      <= C_PT[DISP_LSB +: 8];
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pass_mask <= 3'b000;
                        r_fail_mask <= 3'b000;
                        r_pass      <= 1'b0;
                        if (!w_illegal) begin
                            r_busy  <= 1'b1;
                            r_auto  <= auto_all;
                            r_mode  <= auto_all ? 2'd0 : mode_sel;
                            r_phase <= 1'b0;
                            r_din   <= C_PT;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_round <= '0;
                    r_tmo   <= '0;
                end
                S_WAIT: begin
                    if (core_round_valid) begin
                        if (r_round != '1) r_round <= r_round + 1'b1;
                        r_disp <= core_dout[DISP_LSB +: 8];
                    end
                    if (core_done) begin
                        r_result <= core_dout;
                        r_disp   <= core_dout[DISP_LSB +: 8];
                    end else if (w_tmo_hit) begin
                        r_fail_mask <= r_fail_mask | w_mode_bit;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_check_ok && !r_phase) begin
                        r_phase <= 1'b1;
                        r_din   <= r_result;
                    end else if (w_check_ok) begin
                        r_pass_mask <= r_pass_mask | w_mode_bit;
                    end else begin
                        r_fail_mask <= r_fail_mask | w_mode_bit;
                    end
                end
                S_NEXT: begin
                    if (w_more) begin
                        r_mode  <= r_mode + 2'd1;
                        r_phase <= 1'b0;
                        r_din   <= C_PT;
                    end else begin
                        r_pass <= (r_fail_mask == 3'b000) &&
                                  ((r_pass_mask & w_tested) == w_tested);
                    end
                end
                S_FINISH: r_busy <= 1'b0;
                default:  ;
            endcase
        end
    end

    assign core_start   = w_core_start;
    assign core_mode    = r_mode;
    assign core_decrypt = r_phase;
    assign core_din     = r_din;
    assign busy         = r_busy;
    assign done         = w_done;
    assign pass         = r_pass;
    assign pass_mask    = r_pass_mask;
    assign fail_mask    = r_fail_mask;
    assign round_num    = r_round;
    assign phase        = r_phase;
    assign disp_byte    = r_disp;

endmodule

`default_nettype wire

// File: tb/tb_aes_selftest_sequencer.sv
// ============================================================================
// Module   : tb_aes_selftest_sequencer
// Brief    : Directed self-checking bench for aes_selftest_sequencer with a
//            scripted AES core model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_selftest_sequencer;

    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C_CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         auto_all;
    logic [1:0]   mode_sel;
    logic         core_start;
    logic [1:0]   core_mode;
    logic         core_decrypt;
    logic [127:0] core_din;
    logic         core_round_valid;
    logic [127:0] core_dout;
    logic         core_done;
    logic         busy;
    logic         done;
    logic         pass;
    logic [2:0]   pass_mask;
    logic [2:0]   fail_mask;
    logic [4:0]   round_num;
    logic         phase;
    logic [7:0]   disp_byte;

    aes_selftest_sequencer #(
        .DATA_W    (128),
        .TIMEOUT   (64),
        .DISP_BYTE (15),
        .RND_W     (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .auto_all         (auto_all),
        .mode_sel         (mode_sel),
        .core_start       (core_start),
        .core_mode        (core_mode),
        .core_decrypt     (core_decrypt),
        .core_din         (core_din),
        .core_round_valid (core_round_valid),
        .core_dout        (core_dout),
        .core_done        (core_done),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .pass_mask        (pass_mask),
        .fail_mask        (fail_mask),
        .round_num        (round_num),
        .phase            (phase),
        .disp_byte        (disp_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters, read only at negedges where the pulse is low.
    int done_cnt   = 0;
    int launch_cnt = 0;
    always @(negedge clk) begin
        if (done)       done_cnt   = done_cnt + 1;
        if (core_start) launch_cnt = launch_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int start_cyc;
    int launch_at;
    int done_at;
    logic [127:0] ct_tab [3];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_busy"},      busy,         1'b0);
        chk({pfx, "_done"},      done,         1'b0);
        chk({pfx, "_pass"},      pass,         1'b0);
        chk({pfx, "_pass_mask"}, pass_mask,    3'b000);
        chk({pfx, "_fail_mask"}, fail_mask,    3'b000);
        chk({pfx, "_round_num"}, round_num,    5'd0);
        chk({pfx, "_phase"},     phase,        1'b0);
        chk({pfx, "_disp"},      disp_byte,    8'hff);
        chk({pfx, "_cstart"},    core_start,   1'b0);
        chk({pfx, "_cmode"},     core_mode,    2'd0);
        chk({pfx, "_cdec"},      core_decrypt, 1'b0);
        chk({pfx, "_cdin"},      core_din,     128'h0);
    endtask

    task automatic do_start(input logic [1:0] m, input logic a);
        @(posedge clk);
        #1;
        start     = 1'b1;
        mode_sel  = m;
        auto_all  = a;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start    = 1'b0;
        auto_all = 1'b0;
        mode_sel = 2'd0;
    endtask

    task automatic wait_launch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (core_start) begin
                ok = 1'b1;
                break;
            end
        end
        launch_at = cyc;
        chk("launch_seen", ok, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        done_at = cyc;
        chk("done_seen", seen, 1'b1);
    endtask

    // Scripted core: n round pulses, the last carrying the result (and done).
    task automatic run_core(input logic [1:0] m, input logic dec, input logic [127:0] din,
                            input int n, input logic [127:0] res, input logic give_done);
        bit ok;
        wait_launch(ok);
        if (!ok) return;
        chk("core_mode",    core_mode,    m);
        chk("core_decrypt", core_decrypt, dec);
        chk("core_din",     core_din,     din);
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            #1;
            core_round_valid = 1'b1;
            core_dout        = (i == n - 1) ? res : {16{8'(i + 1)}};
            core_done        = give_done && (i == n - 1);
            @(posedge clk);
        end
        #1;
        core_round_valid = 1'b0;
        core_done        = 1'b0;
        core_dout        = 128'h0;
        chk("core_din_hold", core_din, din);
    endtask

    initial begin
        int d0;
        int l0;
        bit ok;
        ct_tab[0] = C_CT0;
        ct_tab[1] = C_CT1;
        ct_tab[2] = C_CT2;
        reset = 1'b1; start = 1'b0; auto_all = 1'b0; mode_sel = 2'd0;
        core_round_valid = 1'b0; core_dout = 128'h0; core_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b0;

        // Single mode 0, ideal core, 11 cycles per phase
        do_start(2'd0, 1'b0);
        run_core(2'd0, 1'b0, C_PT, 11, C_CT0, 1'b1);
        chk("t1_enc_disp",   disp_byte, 8'h5a);
        chk("t1_enc_rounds", round_num, 5'd11);
        run_core(2'd0, 1'b1, C_CT0, 11, C_PT, 1'b1);
        wait_done(20);
        chk("t1_latency",   done_at - start_cyc, 28);
        chk("t1_pass",      pass,      1'b1);
        chk("t1_pass_mask", pass_mask, 3'b001);
        chk("t1_fail_mask", fail_mask, 3'b000);
        chk("t1_disp",      disp_byte, 8'hff);
        chk("t1_busy_fin",  busy,      1'b1);
        @(negedge clk);
        chk("t1_busy_idle", busy, 1'b0);
        chk("t1_done_low",  done, 1'b0);

        // All three modes in sequence
        d0 = done_cnt;
        l0 = launch_cnt;
        do_start(2'd2, 1'b1);
        for (int m = 0; m < 3; m++) begin
            run_core(2'(m), 1'b0, C_PT,      11 + 2 * m, ct_tab[m], 1'b1);
            run_core(2'(m), 1'b1, ct_tab[m], 11 + 2 * m, C_PT,      1'b1);
        end
        wait_done(20);
        chk("t2_pass",      pass,      1'b1);
        chk("t2_pass_mask", pass_mask, 3'b111);
        chk("t2_fail_mask", fail_mask, 3'b000);
        repeat (3) @(negedge clk);
        chk("t2_done_cnt",   done_cnt - d0,   1);
        chk("t2_launch_cnt", launch_cnt - l0, 6);

        // Illegal mode 3: immediate finish, masks cleared
        l0 = launch_cnt;
        do_start(2'd3, 1'b0);
        wait_done(5);
        chk("t3_latency",   done_at - start_cyc, 1);
        chk("t3_pass",      pass,      1'b0);
        chk("t3_pass_mask", pass_mask, 3'b000);
        chk("t3_fail_mask", fail_mask, 3'b000);
        repeat (2) @(negedge clk);
        chk("t3_no_launch", launch_cnt - l0, 0);

        // Mode 1, corrupted ciphertext: no decrypt launch
        l0 = launch_cnt;
        do_start(2'd1, 1'b0);
        run_core(2'd1, 1'b0, C_PT, 13, C_CT1 ^ 128'h1, 1'b1);
        wait_done(150);
        chk("t4_fail_mask", fail_mask, 3'b010);
        chk("t4_pass_mask", pass_mask, 3'b000);
        chk("t4_pass",      pass,      1'b0);
        chk("t4_disp",      disp_byte, 8'h90);
        repeat (2) @(negedge clk);
        chk("t4_launch_cnt", launch_cnt - l0, 1);

        // Mode 2, one round pulse short
        do_start(2'd2, 1'b0);
        run_core(2'd2, 1'b0, C_PT, 14, C_CT2, 1'b1);
        wait_done(150);
        chk("t5_fail_mask", fail_mask, 3'b100);
        chk("t5_pass",      pass,      1'b0);
        chk("t5_rounds",    round_num, 5'd14);

        // Silent core: timeout, with an ignored start mid-wait
        l0 = launch_cnt;
        do_start(2'd0, 1'b0);
        wait_launch(ok);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1; mode_sel = 2'd1; auto_all = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mode_sel = 2'd0; auto_all = 1'b0;
        @(negedge clk);
        chk("t6_busy_mid",  busy,      1'b1);
        chk("t6_mode_mid",  core_mode, 2'd0);
        wait_done(100);
        chk("t6_latency",   done_at - launch_at, 66);
        chk("t6_fail_mask", fail_mask, 3'b001);
        chk("t6_pass_mask", pass_mask, 3'b000);
        chk("t6_pass",      pass,      1'b0);
        chk("t6_rounds",    round_num, 5'd0);
        repeat (3) @(negedge clk);
        chk("t6_launch_cnt", launch_cnt - l0, 1);

        // Reset during decrypt wait, then a clean run
        d0 = done_cnt;
        do_start(2'd0, 1'b0);
        run_core(2'd0, 1'b0, C_PT, 11, C_CT0, 1'b1);
        wait_launch(ok);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            core_round_valid = 1'b1;
            core_dout        = {16{8'(i + 1)}};
            @(posedge clk);
        end
        #1;
        core_round_valid = 1'b0;
        core_dout        = 128'h0;
        chk("t7_disp_mid",   disp_byte, 8'h03);
        chk("t7_rounds_mid", round_num, 5'd3);
        chk("t7_phase_mid",  phase,     1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("t7_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_no_done", done_cnt - d0, 0);
        do_start(2'd0, 1'b0);
        run_core(2'd0, 1'b0, C_PT,  11, C_CT0, 1'b1);
        run_core(2'd0, 1'b1, C_CT0, 11, C_PT,  1'b1);
        wait_done(20);
        chk("t7_pass",      pass,      1'b1);
        chk("t7_pass_mask", pass_mask, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_selftest_sequencer.md
Name: aes_selftest_sequencer

Overview:
Sequencer that runs FIPS-197 known-answer self-tests on an external AES cipher/inverse-cipher core across key sizes 128/192/256. For each mode it encrypts a fixed plaintext, checks the ciphertext and round count, decrypts the result, and checks recovery of the plaintext. It latches per-mode pass/fail, tracks the live round number, and exports one selectable state byte for the 7-segment BCD path.

Parameters:
DATA_W, 128, block width in bits; only 128 is legal.
TIMEOUT, 64, maximum cycles from core_start to core_done before the test is declared failed.
DISP_BYTE, 15, index of the state byte driven on disp_byte; byte 0 is most significant.
RND_W, 5, width of the round counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that launches a test run; ignored while busy
auto_all  in  1  sampled on start: 1 runs all three modes in order 0,1,2; 0 runs only mode_sel
mode_sel  in  2  key size select: 0=128, 1=192, 2=256; 3 is illegal
core_start  out  1  one-cycle pulse to the core
core_mode  out  2  key size presented to the core
core_decrypt  out  1  0=cipher, 1=inverse cipher
core_din  out  DATA_W  input block to the core
core_round_valid  in  1  pulse for each completed core round, including the initial AddRoundKey
core_dout  in  DATA_W  core state; valid while core_round_valid or core_done is high
core_done  in  1  final-round pulse with the result on core_dout
busy  out  1  run in progress
done  out  1  one-cycle pulse at the end of a run
pass  out  1  registered result of the last run: all tested modes passed
pass_mask  out  3  per-mode pass bits for the last run
fail_mask  out  3  per-mode fail bits for the last run
round_num  out  RND_W  rounds seen in the current phase
phase  out  1  0=encrypt, 1=decrypt
disp_byte  out  8  byte DISP_BYTE of the last captured core_dout; plaintext byte at reset

Behaviour:
- Reset values: every output 0, except disp_byte = plaintext byte DISP_BYTE = 8'hff. FSM goes to IDLE. Reset mid-run aborts immediately with no done pulse.
- Constants:
  - PT = 00112233445566778899aabbccddeeff
  - CT0 = 69c4e0d86a7b0430d8cdb78070b4c55a
  - CT1 = dda97ca4864cdfe06eaf70a0ec0d7191
  - CT2 = 8ea2b7ca516745bfeafc49904b496089
  - Nr per mode: 10, 12, 14. Expected round pulses = Nr+1.
- FSM states: IDLE, LAUNCH, WAIT, CHECK, NEXT, FINISH.
- IDLE:
  - start with mode_sel=3 and auto_all=0 goes straight to FINISH with fail_mask=3'b000, pass=0.
  - Otherwise, on start: clear both masks, set busy=1, load the mode, set phase=0, go to LAUNCH.
- LAUNCH:
  - Pulse core_start for exactly 1 cycle.
  - core_din = PT when encrypting, the captured ciphertext when decrypting.
  - Clear round_num and the timeout counter; go to WAIT.
  - core_mode, core_decrypt and core_din stay stable from LAUNCH until the cycle after core_done.
- WAIT:
  - Each core_round_valid increments round_num, saturating at all-ones, and captures core_dout into the display register.
  - core_done captures core_dout as the result and goes to CHECK. If core_round_valid and core_done arrive in the same cycle, the round counts.
  - When the timeout counter reaches TIMEOUT-1, the mode fails and the FSM goes to NEXT.
- CHECK (1 cycle):
  - The phase fails if the result is not the expected value (phase 0: CTm; phase 1: PT) or if round_num is not Nr+1.
  - Phase 0 pass: set phase=1, go to LAUNCH.
  - Phase 1 pass: set pass_mask[m], go to NEXT.
  - Any fail: set fail_mask[m], go to NEXT. Decrypt is skipped after an encrypt fail.
- NEXT:
  - If auto_all=1 and m<2: m=m+1, phase=0, go to LAUNCH.
  - Otherwise go to FINISH.
- FINISH:
  - Pulse done for 1 cycle.
  - pass = 1 only if fail_mask==0 and pass_mask covers every tested mode.
  - Clear busy, return to IDLE.
- start while busy is ignored; core_done outside WAIT is ignored.
- Latency for one mode with a core that takes R cycles per phase: 2*(R+2)+2 cycles from start to done.

Test Plan:
- Reset, then start, mode_sel=0, auto_all=0; ideal core returns CT0 after 11 round pulses, then PT after 11 -> done, pass=1, pass_mask=001, disp_byte=ff.
- auto_all=1, ideal core for all modes -> three encrypt/decrypt pairs with core_mode 0,1,2; pass_mask=111, pass=1, a single done pulse.
- mode_sel=1, core returns CT1 with bit 0 flipped -> fail_mask=010, no decrypt launch, pass=0.
- mode_sel=2, core gives 14 round pulses instead of 15 but the correct CT2 -> fail_mask=100.
- core never asserts core_done, TIMEOUT=64 -> failure 64 cycles after core_start, done pulse, pass=0; a start pulse mid-wait is ignored.
- reset asserted in WAIT of the decrypt phase -> all outputs 0 and disp_byte=ff next cycle, no done pulse; a fresh start then passes normally.
